// File: rtl/light_seq_scheduler.sv
// Light-frame sequencer: plays a programmable table of frames to the SPI TX block,
// one valid/ready transfer per step followed by a per-step dwell, one-shot or looped.
module light_seq_scheduler #(
    parameter  int NSTEP  = 8,
    parameter  int DATA_W = 24,
    parameter  int DLY_W  = 32,
    localparam int AW     = $clog2(NSTEP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DLY_W-1:0]  cfg_dwell,
    input  logic [AW:0]       num_steps,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic [AW-1:0]     step_idx,
    output logic              seq_done,
    output logic [2:0]        dbg_state
);

    // Handshake: a frame moves on any rising clk edge where tx_valid and tx_ready are
    // both 1; once raised, tx_valid and tx_data hold until that edge (stop cannot cut it).

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_DWELL = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] tbl_data  [NSTEP];
    logic [DLY_W-1:0]  tbl_dwell [NSTEP];
    logic [DLY_W-1:0]  dwell_reg;
    logic [DLY_W-1:0]  count;
    logic [AW:0]       n_reg;
    logic [AW:0]       last_idx;
    logic [AW:0]       n_clamped;
    logic              stop_pend;
    logic              at_last;

    assign dbg_state = state;
    assign last_idx  = n_reg - (AW+1)'(1);
    assign at_last   = ({1'b0, step_idx} == last_idx);
    assign n_clamped = (num_steps > (AW+1)'(NSTEP)) ? (AW+1)'(NSTEP) : num_steps;

    // Table RAM has no reset; the host may only rewrite it while playback is idle.
    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            tbl_data[cfg_addr]  <= cfg_data;
            tbl_dwell[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            step_idx  <= '0;
            seq_done  <= 1'b0;
            count     <= '0;
            dwell_reg <= '0;
            n_reg     <= '0;
            stop_pend <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !stop && num_steps != '0) begin
                        n_reg    <= n_clamped;
                        step_idx <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        step_idx <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tx_data   <= tbl_data[step_idx];
                        dwell_reg <= tbl_dwell[step_idx];
                        tx_valid  <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        count     <= '0;
                        stop_pend <= 1'b0;
                        if (stop || stop_pend) begin
                            step_idx <= '0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            state <= S_DWELL;
                        end
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                S_DWELL: begin
                    if (stop) begin
                        step_idx <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (count == dwell_reg) begin
                        state <= S_NEXT;
                    end else begin
                        count <= count + DLY_W'(1);
                    end
                end
                S_NEXT: begin
                    // loop_en is read live here; n_reg stays as latched at start.
                    if (stop) begin
                        step_idx <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (!at_last) begin
                        step_idx <= step_idx + AW'(1);
                        state    <= S_LOAD;
                    end else if (loop_en) begin
                        step_idx <= '0;
                        state    <= S_LOAD;
                    end else begin
                        step_idx <= '0;
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    step_idx <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_seq_scheduler.sv
// Bench for light_seq_scheduler: directed scenarios plus random traffic, checked each
// cycle against an event-timeline model and a transferred-frame scoreboard.
module tb_light_seq_scheduler;

    localparam int NSTEP  = 8;
    localparam int DATA_W = 24;
    localparam int DLY_W  = 32;
    localparam int AW     = $clog2(NSTEP);

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic [DLY_W-1:0]  cfg_dwell = '0;
    logic [AW:0]       num_steps = '0;
    logic              loop_en = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              tx_ready = 1'b0;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic [AW-1:0]     step_idx;
    logic              seq_done;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    light_seq_scheduler #(.NSTEP(NSTEP), .DATA_W(DATA_W), .DLY_W(DLY_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_dwell(cfg_dwell), .num_steps(num_steps),
        .loop_en(loop_en), .start(start), .stop(stop), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .step_idx(step_idx),
        .seq_done(seq_done), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // Playback is tracked as absolute edge numbers: the edge at which the next frame
    // is offered, and the edge at which the end-of-step decision is taken.
    logic [DATA_W-1:0] m_data_tbl  [NSTEP];
    logic [DLY_W-1:0]  m_dwell_tbl [NSTEP];
    logic [DATA_W-1:0] exp_q[$];
    int  cyc = 0;
    bit  m_act = 0, m_offer = 0, m_sd = 0, m_stop_pend = 0, m_zero = 1;
    int  m_pos = 0, m_n = 0, offer_at = -1, decide_at = -1;
    logic [DATA_W-1:0] m_cur = '0;

    always @(posedge clk) begin
        cyc++;
        m_sd = 0;
        if (reset) begin
            m_act = 0; m_offer = 0; m_pos = 0; m_stop_pend = 0; m_zero = 1;
            offer_at = -1; decide_at = -1;
            exp_q.delete();
        end else if (!m_act) begin
            if (cfg_we) begin
                m_data_tbl[cfg_addr]  = cfg_data;
                m_dwell_tbl[cfg_addr] = cfg_dwell;
            end
            if (start && !stop && num_steps != 0) begin
                m_act = 1;
                m_n = (int'(num_steps) > NSTEP) ? NSTEP : int'(num_steps);
                m_pos = 0;
                offer_at = cyc + 1;
            end
        end else if (m_offer) begin
            if (stop) m_stop_pend = 1;
            if (tx_ready) begin
                m_offer = 0;
                if (m_stop_pend) begin
                    m_act = 0; m_pos = 0; m_stop_pend = 0;
                end else begin
                    decide_at = cyc + int'(m_dwell_tbl[m_pos]) + 2;
                end
            end
        end else if (stop) begin
            m_act = 0; m_pos = 0; offer_at = -1; decide_at = -1;
        end else if (cyc == offer_at) begin
            m_offer = 1; m_zero = 0; offer_at = -1;
            m_cur = m_data_tbl[m_pos];
            exp_q.push_back(m_cur);
        end else if (cyc == decide_at) begin
            decide_at = -1;
            if (m_pos < m_n - 1) begin
                m_pos++; offer_at = cyc + 1;
            end else if (loop_en) begin
                m_pos = 0; offer_at = cyc + 1;
            end else begin
                m_act = 0; m_pos = 0; m_sd = 1;
            end
        end
    end

    // ---------------- checking ----------------
    int tests = 0, fails = 0, sd_seen = 0, xfers = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("busy", 64'(busy), 64'(m_act));
        check_eq("tx_valid", 64'(tx_valid), 64'(m_offer));
        check_eq("step_idx", 64'(step_idx), 64'(m_pos));
        check_eq("seq_done", 64'(seq_done), 64'(m_sd));
        if (m_offer) check_eq("tx_data", 64'(tx_data), 64'(m_cur));
        if (m_zero) check_eq("tx_data_rst", 64'(tx_data), 64'(0));
        if (seq_done) sd_seen++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (!reset && tx_valid && tx_ready) begin
            xfers++;
            check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check_eq("sb_frame", 64'(tx_data), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic cfg_write(input int addr, input logic [DATA_W-1:0] data, input int dwell);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data; cfg_dwell = DLY_W'(dwell);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int i;
        for (i = 0; i < budget && !tx_valid; i++) tick();
        check_eq("wait_valid", 64'(tx_valid), 64'(1));
    endtask

    task automatic run_idle(input int budget);
        int i;
        for (i = 0; i < budget && busy; i++) tick();
        check_eq("run_idle", 64'(busy), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    int sd0, x0;

    initial begin
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        for (int a = 0; a < NSTEP; a++) cfg_write(a, DATA_W'($urandom), $urandom_range(0, 3));

        // one-shot, two steps, ready always high
        cfg_write(0, 24'hA1A2A3, 2);
        cfg_write(1, 24'hB1B2B3, 0);
        num_steps = 2; loop_en = 0; tx_ready = 1;
        sd0 = sd_seen;
        pulse_start();
        run_idle(100);
        check_eq("oneshot_done_pulses", 64'(sd_seen - sd0), 64'(1));

        // back-pressure in SEND
        tx_ready = 0; num_steps = 1;
        pulse_start();
        wait_valid(20);
        repeat (5) tick();
        tx_ready = 1;
        run_idle(100);

        // looped playback, then loop_en cleared
        num_steps = 3; loop_en = 1; sd0 = sd_seen;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        check_eq("loop_no_done", 64'(sd_seen - sd0), 64'(0));
        loop_en = 0; tx_ready = 1;
        run_idle(200);
        check_eq("loop_end_done", 64'(sd_seen - sd0), 64'(1));

        // stop during SEND with ready low
        num_steps = 2; tx_ready = 0; sd0 = sd_seen;
        pulse_start();
        wait_valid(20);
        stop = 1; tick(); stop = 0;
        tick(); tick();
        tx_ready = 1;
        run_idle(50);
        check_eq("stop_send_no_done", 64'(sd_seen - sd0), 64'(0));

        // stop during DWELL
        cfg_write(0, DATA_W'($urandom), 6);
        num_steps = 1;
        pulse_start();
        wait_valid(20);
        tick(); tick(); tick();
        stop = 1; tick(); stop = 0;
        check_eq("stop_dwell_busy", 64'(busy), 64'(0));

        // zero steps, oversize step count, writes while busy
        num_steps = 0;
        pulse_start();
        check_eq("zero_steps_busy", 64'(busy), 64'(0));
        num_steps = (AW+1)'(NSTEP + 3); x0 = xfers;
        pulse_start();
        for (int i = 0; i < 4; i++) cfg_write(0, DATA_W'($urandom), 1);
        run_idle(400);
        check_eq("oversize_xfers", 64'(xfers - x0), 64'(NSTEP));
        num_steps = 1;
        pulse_start();
        run_idle(100);

        // reset in DWELL, reset in SEND, then a fresh run
        cfg_write(0, DATA_W'($urandom), 6);
        pulse_start();
        wait_valid(20);
        tick(); tick();
        reset = 1; tick(); reset = 0;
        tx_ready = 0;
        pulse_start();
        wait_valid(20);
        reset = 1; tick(); reset = 0;
        check_eq("reset_send_valid", 64'(tx_valid), 64'(0));
        tx_ready = 1; num_steps = 2;
        pulse_start();
        run_idle(100);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tx_ready  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
            num_steps = (AW+1)'($urandom_range(0, 2 * NSTEP - 1));
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_addr  = AW'($urandom_range(0, NSTEP - 1));
            cfg_data  = DATA_W'($urandom);
            cfg_dwell = DLY_W'($urandom_range(0, 4));
            tick();
        end
        start = 0; stop = 0; reset = 0; cfg_we = 0; loop_en = 0; tx_ready = 1;
        run_idle(1000);
        check_eq("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
